regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//  Parametrised general-purpose register file for the datapath: NUM_RD async read ports, two
//  write ports (WB + second retire slot), optional hardwired zero register and write->read bypass.
//  Contents are cleared by a built-in sequencer after reset. busy is high while clearing.
//  Sits between decode (read addresses) and write-back (write ports).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; depth NUM_REGS = 2**ADDR_W
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  1   1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
//  BYPASS    1   1: same-cycle write data forwarded to matching read port; 0: old value read
// PORTS
//  clk       in   1               rising-edge clock
//  reset     in   1               synchronous, active-high reset
//  rd_addr   in   NUM_RD*ADDR_W   read addresses, port i at [i*ADDR_W +: ADDR_W]
//  rd_data   out  NUM_RD*DATA_W   read data, port i at [i*DATA_W +: DATA_W]
//  we0       in   1               write enable, port 0
//  waddr0    in   ADDR_W          write address, port 0
//  wdata0    in   DATA_W          write data, port 0
//  we1       in   1               write enable, port 1 (priority port)
//  waddr1    in   ADDR_W          write address, port 1
//  wdata1    in   DATA_W          write data, port 1
//  busy      out  1               clear sequence in progress; writes ignored
// BEHAVIOUR
//  - One clock (clk); reset is synchronous, active-high. All state updates on posedge clk only.
//  - FSM, 2 states: CLEAR, READY. Sampled reset=1 -> CLEAR, clr_cnt=0 (from any state, including
//    mid-CLEAR, which restarts at 0). In CLEAR, each cycle writes 0 to regs[clr_cnt] and increments it.
//    If clr_cnt==NUM_REGS-1 -> READY on the next edge. Clear takes exactly NUM_REGS cycles after reset drops.
//  - busy = (state==CLEAR). It is registered: 1 in the cycle after reset is sampled, and 0 in the
//    first READY cycle.
//  - Writes (READY only): weN=1 writes wdataN to regs[waddrN] at posedge. During CLEAR or
//    reset, we0/we1 are ignored and not queued.
//  - Same-address dual write: port 1 wins; port 0 data is discarded.
//  - ZERO_REG=1: writes to address 0 are dropped; any read of address 0 returns 0 (including bypass).
//  - Reads: combinational in rd_addr and the array, 0 cycles latency. They must be sensitive to
//    array contents, not only addresses. While busy=1 every rd_data is 0.
//  - BYPASS=1, READY: if port 1 writes the read address this cycle -> wdata1. Else if port 0
//    writes it -> wdata0. Else the stored value. BYPASS=0: the stored value, and the new data is
//    visible the cycle after the write.
//  - Reset values: busy=1 after reset is sampled; rd_data=0 during CLEAR; all regs 0 at end of CLEAR.
//  - No X on rd_data after clear; out-of-range addresses are impossible (depth = 2**ADDR_W).
// STRUCTURE
//  - regfile_pkg: state encoding (ST_CLEAR, ST_READY), default width/depth constants, ZERO_ADDR.
//  - Sub-module regfile_clear_seq: FSM and clr_cnt. Outputs busy, clr_we and clr_addr, muxed
//    onto the array write path ahead of user writes.
//  - Read port logic is a generate loop over NUM_RD, with identical bypass/zero muxing per port.
// TESTING
//  1. reset=1 for 3 cycles, then 0 -> busy=1 for exactly 32 cycles, then 0. All 32 regs then
//     read 0; writes issued while busy are lost.
//  2. READY: we0=1, waddr0=5, wdata0=32'hDEADBEEF; next cycle rd_addr[0]=5 -> 32'hDEADBEEF.
//     With BYPASS=1 this value also appears in the write cycle itself.
//  3. we0=we1=1, waddr0=waddr1=7, wdata0=32'h1111, wdata1=32'h2222 -> reg7=32'h2222.
//     Same-cycle bypass also returns 32'h2222.
//  4. ZERO_REG=1: write 32'hFFFF_FFFF to addr 0 -> rd_data=0 in the same cycle and all later cycles.
//     ZERO_REG=0 build: the value 32'hFFFF_FFFF is stored.
//  5. Reset asserted at clear cycle 10 -> counter restarts; busy stays high 32 more cycles;
//     regs written pre-reset read 0 afterwards.
//  6. NUM_RD=3, DATA_W=16, ADDR_W=3 build: random writes vs. scoreboard model over 1000 cycles.
//     Port 1 priority, bypass and zero-reg are checked on all 3 read ports.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: clear-sequencer state
// encoding, default geometry and the address of the optional hardwired zero register.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every register address once, writing zero,
// and holds busy until the walk completes.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (reset) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
    end else if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == LAST_ADDR) state_d = ST_READY;
    end
  end

  // NOTE: non-blocking assignments here so every flop samples the pre-edge
  // values regardless of process ordering in simulation.
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_cnt_q <= clr_cnt_d;
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = (state_q == ST_CLEAR) && !reset;
  assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/regfile_multiport.sv
// Register file with NUM_RD asynchronous read ports, two write ports (port 1 wins
// on address collision), optional zero register and same-cycle write bypass.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  output logic                     busy
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_ADDR);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr0_en, wr1_en;

  // NOTE: the array has no reset term; the clear sequencer zeroes it through the
  // normal write path, which keeps it mappable onto plain storage.
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // User writes are live only in READY and outside reset; zero-register writes vanish here.
  assign wr0_en = we0 && !busy && !reset && !(ZERO_REG && (waddr0 == ZERO_A));
  assign wr1_en = we1 && !busy && !reset && !(ZERO_REG && (waddr1 == ZERO_A));

  always_comb begin
    regs_d = regs_q;
    if (clr_we) regs_d[clr_addr] = '0;
    if (wr0_en) regs_d[waddr0] = wdata0;
    if (wr1_en) regs_d[waddr1] = wdata1;
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs_q[addr];
      if (BYPASS && wr1_en && (waddr1 == addr)) begin
        data = wdata1;
      end else if (BYPASS && wr0_en && (waddr0 == addr)) begin
        data = wdata0;
      end
      if (busy || (ZERO_REG && (addr == ZERO_A))) data = '0;
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench: three register-file builds (default; 16x8x3 with zero/bypass;
// 16x8x3 without) driven with random and directed traffic against an array model.
module tb_regfile_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  bit          we0_s [2];
  bit          we1_s [2];
  logic [4:0]  wa0_s [2];
  logic [4:0]  wa1_s [2];
  logic [31:0] wd0_s [2];
  logic [31:0] wd1_s [2];
  logic [4:0]  ra_s  [2][3];

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic        a_busy;
  logic [8:0]  bc_rd_addr;
  logic [47:0] b_rd_data, c_rd_data;
  logic        b_busy, c_busy;

  assign a_rd_addr  = {ra_s[0][1], ra_s[0][0]};
  assign bc_rd_addr = {ra_s[1][2][2:0], ra_s[1][1][2:0], ra_s[1][0][2:0]};

  regfile_multiport #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .we0(we0_s[0]), .waddr0(wa0_s[0]), .wdata0(wd0_s[0]),
    .we1(we1_s[0]), .waddr1(wa1_s[0]), .wdata1(wd1_s[0]), .busy(a_busy)
  );

  regfile_multiport #(
    .DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .rd_addr(bc_rd_addr), .rd_data(b_rd_data),
    .we0(we0_s[1]), .waddr0(wa0_s[1][2:0]), .wdata0(wd0_s[1][15:0]),
    .we1(we1_s[1]), .waddr1(wa1_s[1][2:0]), .wdata1(wd1_s[1][15:0]), .busy(b_busy)
  );

  regfile_multiport #(
    .DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dut_c (
    .clk(clk), .reset(reset), .rd_addr(bc_rd_addr), .rd_data(c_rd_data),
    .we0(we0_s[1]), .waddr0(wa0_s[1][2:0]), .wdata0(wd0_s[1][15:0]),
    .we1(we1_s[1]), .waddr1(wa1_s[1][2:0]), .wdata1(wd1_s[1][15:0]), .busy(c_busy)
  );

  // Reference model: d=0 -> dut_a, d=1 -> dut_b, d=2 -> dut_c.
  logic [31:0] mem [3][32];
  int          rem [3];

  typedef struct {
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int depth(int d);
    return (d == 0) ? 32 : 8;
  endfunction

  function automatic int grp(int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic bit has_zero_byp(int d);
    return d != 2;
  endfunction

  function automatic logic [31:0] model_rd(int d, int p);
    int g    = grp(d);
    int addr = int'(ra_s[g][p]);
    if (rem[d] != 0) return 32'h0;
    if (has_zero_byp(d) && addr == 0) return 32'h0;
    if (has_zero_byp(d) && !reset && we1_s[g] && int'(wa1_s[g]) == addr) return wd1_s[g];
    if (has_zero_byp(d) && !reset && we0_s[g] && int'(wa0_s[g]) == addr) return wd0_s[g];
    return mem[d][addr];
  endfunction

  task automatic model_update();
    for (int d = 0; d < 3; d++) begin
      int g = grp(d);
      if (reset) begin
        rem[d] = depth(d);
      end else if (rem[d] != 0) begin
        rem[d]--;
        if (rem[d] == 0) for (int r = 0; r < 32; r++) mem[d][r] = 32'h0;
      end else begin
        if (we0_s[g] && !(has_zero_byp(d) && wa0_s[g] == 5'd0)) mem[d][wa0_s[g]] = wd0_s[g];
        if (we1_s[g] && !(has_zero_byp(d) && wa1_s[g] == 5'd0)) mem[d][wa1_s[g]] = wd1_s[g];
      end
    end
  endtask

  task automatic push_expect();
    for (int d = 0; d < 3; d++) begin
      int np = (d == 0) ? 2 : 3;
      for (int p = 0; p < np; p++) sb_q.push_back('{d, p, model_rd(d, p)});
      sb_q.push_back('{d, -1, (rem[d] != 0) ? 32'h1 : 32'h0});
    end
  endtask

  task automatic cycle();
    push_expect();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic no_writes();
    for (int g = 0; g < 2; g++) begin
      we0_s[g] = 1'b0;
      we1_s[g] = 1'b0;
    end
  endtask

  task automatic rand_inputs();
    for (int g = 0; g < 2; g++) begin
      int n = depth(g);
      we0_s[g] = 1'($urandom_range(0, 1));
      we1_s[g] = 1'($urandom_range(0, 1));
      wa0_s[g] = 5'($urandom_range(0, n - 1));
      wa1_s[g] = ($urandom_range(0, 3) == 0) ? wa0_s[g] : 5'($urandom_range(0, n - 1));
      wd0_s[g] = (g == 0) ? $urandom : 32'($urandom_range(0, 65535));
      wd1_s[g] = (g == 0) ? $urandom : 32'($urandom_range(0, 65535));
      for (int p = 0; p < 3; p++) begin
        case ($urandom_range(0, 5))
          0:       ra_s[g][p] = wa0_s[g];
          1:       ra_s[g][p] = wa1_s[g];
          2:       ra_s[g][p] = 5'd0;
          default: ra_s[g][p] = 5'($urandom_range(0, n - 1));
        endcase
      end
    end
  endtask

  task automatic read_all();
    no_writes();
    for (int i = 0; i < 16; i++) begin
      ra_s[0][0] = 5'(2 * i);
      ra_s[0][1] = 5'(2 * i + 1);
      for (int p = 0; p < 3; p++) ra_s[1][p] = 5'((i * 3 + p) % 8);
      cycle();
    end
  endtask

  task automatic set_reads(int g, int addr);
    for (int p = 0; p < 3; p++) ra_s[g][p] = 5'(addr);
  endtask

  function automatic logic [31:0] actual(int k, int p);
    case (k)
      0:       return (p < 0) ? {31'b0, a_busy} : a_rd_data[p*32 +: 32];
      1:       return (p < 0) ? {31'b0, b_busy} : {16'b0, b_rd_data[p*16 +: 16]};
      default: return (p < 0) ? {31'b0, c_busy} : {16'b0, c_rd_data[p*16 +: 16]};
    endcase
  endfunction

  // Monitor: drains every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      string       nm;
      e  = sb_q.pop_front();
      nm = $sformatf("%s.%s", (e.kind == 0) ? "a" : (e.kind == 1) ? "b" : "c",
                     (e.port < 0) ? "busy" : $sformatf("rd%0d", e.port));
      check(nm, actual(e.kind, e.port), e.exp);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    no_writes();
    for (int g = 0; g < 2; g++) begin
      wa0_s[g] = '0; wa1_s[g] = '0; wd0_s[g] = '0; wd1_s[g] = '0;
      set_reads(g, 0);
    end
    for (int d = 0; d < 3; d++) rem[d] = depth(d);
    @(posedge clk);
    model_update();
    #1;

    // Reset held three cycles, then a full clear with ignored writes.
    for (int i = 0; i < 2; i++) begin rand_inputs(); cycle(); end
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin rand_inputs(); cycle(); end
    read_all();
    check("a.busy after clear", {31'b0, a_busy}, 32'h0);
    check("b.busy after clear", {31'b0, b_busy}, 32'h0);

    // Single write with same-cycle bypass, then stored readback.
    no_writes();
    we0_s[0] = 1'b1; wa0_s[0] = 5'd5; wd0_s[0] = 32'hDEAD_BEEF;
    set_reads(0, 5);
    #1;
    check("a.rd0 bypass 5", a_rd_data[31:0], 32'hDEAD_BEEF);
    cycle();
    no_writes();
    #1;
    check("a.rd0 stored 5", a_rd_data[31:0], 32'hDEAD_BEEF);
    cycle();

    // Same-address dual write: port 1 wins, bypass included.
    we0_s[0] = 1'b1; wa0_s[0] = 5'd7; wd0_s[0] = 32'h0000_1111;
    we1_s[0] = 1'b1; wa1_s[0] = 5'd7; wd1_s[0] = 32'h0000_2222;
    we0_s[1] = 1'b1; wa0_s[1] = 5'd3; wd0_s[1] = 32'h0000_1111;
    we1_s[1] = 1'b1; wa1_s[1] = 5'd3; wd1_s[1] = 32'h0000_2222;
    set_reads(0, 7);
    set_reads(1, 3);
    #1;
    check("a.rd0 bypass 7", a_rd_data[31:0], 32'h0000_2222);
    check("b.rd2 bypass 3", {16'b0, b_rd_data[47:32]}, 32'h0000_2222);
    cycle();
    no_writes();
    #1;
    check("a.rd1 stored 7", a_rd_data[63:32], 32'h0000_2222);
    check("c.rd0 stored 3", {16'b0, c_rd_data[15:0]}, 32'h0000_2222);
    cycle();

    // Writes to address 0: dropped with zero register, stored without.
    we0_s[0] = 1'b1; wa0_s[0] = 5'd0; wd0_s[0] = 32'hFFFF_FFFF;
    we0_s[1] = 1'b1; wa0_s[1] = 5'd0; wd0_s[1] = 32'h0000_FFFF;
    set_reads(0, 0);
    set_reads(1, 0);
    #1;
    check("a.rd0 zero bypass", a_rd_data[31:0], 32'h0);
    check("b.rd1 zero bypass", {16'b0, b_rd_data[31:16]}, 32'h0);
    cycle();
    no_writes();
    #1;
    check("a.rd0 zero stored", a_rd_data[31:0], 32'h0);
    check("c.rd1 reg0 stored", {16'b0, c_rd_data[31:16]}, 32'h0000_FFFF);
    cycle();
    cycle();

    for (int i = 0; i < 1000; i++) begin rand_inputs(); cycle(); end

    // Reset re-asserted at clear cycle 10 restarts the sequence.
    reset = 1'b1;
    rand_inputs();
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin rand_inputs(); cycle(); end
    reset = 1'b1;
    rand_inputs();
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin rand_inputs(); cycle(); end
    read_all();

    for (int i = 0; i < 20; i++) begin rand_inputs(); cycle(); end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
